// File: rtl/bus_mailbox_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and defaults for bus_mailbox.
package bus_mailbox_pkg;

    localparam int unsigned DefaultDepth = 8;

    // Register select, decoded from addr[3:2].
    typedef enum logic [1:0] {
        RegData    = 2'd0,
        RegStatus  = 2'd1,
        RegControl = 2'd2,
        RegTimer   = 2'd3
    } reg_sel_e;

    // STATUS bit positions.
    localparam int unsigned StatTxFull      = 0;
    localparam int unsigned StatTxEmpty     = 1;
    localparam int unsigned StatRxFull      = 2;
    localparam int unsigned StatRxEmpty     = 3;
    localparam int unsigned StatTxOverflow  = 4;
    localparam int unsigned StatRxUnderflow = 5;
    localparam int unsigned StatTxCount     = 8;
    localparam int unsigned StatRxCount     = 16;

    // CONTROL bit positions.
    localparam int unsigned CtrlClearFlags = 0;
    localparam int unsigned CtrlFlush      = 1;

endpackage

// File: rtl/mailbox_fifo.sv
// Pointer-plus-count FIFO used for both mailbox directions.
// Push is refused when full at the start of the cycle, even if a pop happens
// in the same cycle. Flush overrides any push or pop.
module mailbox_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Stale storage is never visible: head is forced to 0 when empty.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state; async reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/bus_mailbox.sv
// Zero-wait-state bus target: TX/RX mailbox FIFOs, STATUS/CONTROL registers
// and a free-running cycle timer. Reads are combinational; side effects commit
// at the closing clock edge.
module bus_mailbox
    import bus_mailbox_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        cs,
    input  logic        wr_rd,
    input  logic [31:0] data_bus_write,
    output logic [31:0] data_bus_read,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    reg_sel_e      sel;
    logic          bus_wr, bus_rd;
    logic          data_wr, data_rd, ctrl_wr, timer_wr;
    logic          flush, clear_flags;

    logic [31:0]   tx_head, rx_head;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_pop, rx_push, rx_pop;

    logic          tx_ovf_q, tx_ovf_d;
    logic          rx_unf_q, rx_unf_d;
    logic [31:0]   timer_q, timer_d;
    logic [31:0]   status;

    // Only addr[3:2] is decoded; the rest of the address aliases.
    logic unused_addr;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    assign sel         = reg_sel_e'(addr[3:2]);
    assign bus_wr      = cs && wr_rd;
    assign bus_rd      = cs && !wr_rd;
    assign data_wr     = bus_wr && (sel == RegData);
    assign data_rd     = bus_rd && (sel == RegData);
    assign ctrl_wr     = bus_wr && (sel == RegControl);
    assign timer_wr    = bus_wr && (sel == RegTimer);
    assign flush       = ctrl_wr && data_bus_write[CtrlFlush];
    assign clear_flags = ctrl_wr && data_bus_write[CtrlClearFlags];

    // Handshakes use registered full/empty only, so out_ready/in_valid never reach outputs.
    assign tx_pop    = !tx_empty && out_ready;
    assign rx_push   = in_valid && !rx_full;
    assign rx_pop    = data_rd && !rx_empty;
    assign out_valid = !tx_empty;
    assign out_data  = tx_head;
    assign in_ready  = !rx_full;

    mailbox_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .DW    (32)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (tx_pop),
        .flush (flush),
        .wdata (data_bus_write),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    mailbox_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .DW    (32)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .wdata (in_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky flags: a set in the same cycle as a clear wins; flush leaves them alone.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (clear_flags) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
        if (data_wr && tx_full)  tx_ovf_d = 1'b1;
        if (data_rd && rx_empty) rx_unf_d = 1'b1;
    end

    // Timer: bus write takes priority over the increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (timer_wr) timer_d = data_bus_write;
    end

    // Flag and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
            timer_q  <= timer_d;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status                      = '0;
        status[StatTxFull]          = tx_full;
        status[StatTxEmpty]         = tx_empty;
        status[StatRxFull]          = rx_full;
        status[StatRxEmpty]         = rx_empty;
        status[StatTxOverflow]      = tx_ovf_q;
        status[StatRxUnderflow]     = rx_unf_q;
        status[StatTxCount +: CW]   = tx_count;
        status[StatRxCount +: CW]   = rx_count;
    end

    // Zero-latency read mux; idle and write cycles return 0.
    always_comb begin
        data_bus_read = '0;
        if (bus_rd) begin
            unique case (sel)
                RegData:    data_bus_read = rx_head;
                RegStatus:  data_bus_read = status;
                RegControl: data_bus_read = '0;
                RegTimer:   data_bus_read = timer_q;
                default:    data_bus_read = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mailbox.sv
// Self-checking bench for bus_mailbox: queue-based reference model checked
// every negedge, plus directed scenarios with hand-computed expectations.
module tb_bus_mailbox;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        cs;
    logic        wr_rd;
    logic [31:0] data_bus_write;
    logic [31:0] data_bus_read;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    bus_mailbox #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .cs             (cs),
        .wr_rd          (wr_rd),
        .data_bus_write (data_bus_write),
        .data_bus_read  (data_bus_read),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic        m_ovf   = 1'b0;
    logic        m_unf   = 1'b0;
    logic [31:0] m_timer = 32'd0;
    logic        m_tx_was_full, m_rx_was_full;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (txq.size() == DEPTH);
        s[1]     = (txq.size() == 0);
        s[2]     = (rxq.size() == DEPTH);
        s[3]     = (rxq.size() == 0);
        s[4]     = m_ovf;
        s[5]     = m_unf;
        s[11:8]  = 4'(txq.size());
        s[19:16] = 4'(rxq.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read();
        if (!cs || wr_rd) return 32'd0;
        case (addr[3:2])
            2'd0:    return (rxq.size() > 0) ? rxq[0] : 32'd0;
            2'd1:    return model_status();
            2'd3:    return m_timer;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_timer = 32'd0;
        end else begin
            m_tx_was_full = (txq.size() == DEPTH);
            m_rx_was_full = (rxq.size() == DEPTH);
            if (cs && wr_rd && addr[3:2] == 2'd2 && data_bus_write[0]) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (out_ready && txq.size() > 0) void'(txq.pop_front());
            if (cs && wr_rd && addr[3:2] == 2'd0) begin
                if (m_tx_was_full) m_ovf = 1'b1;
                else txq.push_back(data_bus_write);
            end
            if (cs && !wr_rd && addr[3:2] == 2'd0) begin
                if (rxq.size() == 0) m_unf = 1'b1;
                else void'(rxq.pop_front());
            end
            if (in_valid && !m_rx_was_full) rxq.push_back(in_data);
            if (cs && wr_rd && addr[3:2] == 2'd2 && data_bus_write[1]) begin
                txq.delete();
                rxq.delete();
            end
            if (cs && wr_rd && addr[3:2] == 2'd3) m_timer = data_bus_write;
            else m_timer = m_timer + 32'd1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_out_valid", {31'd0, out_valid}, {31'd0, txq.size() > 0});
        check("cyc_out_data", out_data, (txq.size() > 0) ? txq[0] : 32'd0);
        check("cyc_in_ready", {31'd0, in_ready}, {31'd0, rxq.size() < DEPTH});
        check("cyc_bus_read", data_bus_read, model_read());
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] rd;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d;
        @(posedge clk); #1;
        cs = 1'b0; wr_rd = 1'b0; data_bus_write = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        cs = 1'b1; wr_rd = 1'b0; addr = a;
        #2 d = data_bus_read;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic rx_offer(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 32'd0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr_rd = 1'b0; addr = 32'd0; data_bus_write = 32'd0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);
        bus_read(32'h4, rd);
        check("rst_status", rd, 32'h0000_000A);

        // TX fill and overflow
        for (int i = 0; i < 8; i++) bus_write(32'h0, 32'h11 + i);
        bus_write(32'h0, 32'h99);
        bus_read(32'h1000_0004, rd);
        check("fill_status", rd, 32'h0000_0819);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", {31'd0, out_valid}, 32'd1);
            check("drain_data", out_data, 32'h11 + i);
            @(posedge clk); #1;
        end
        check("drain_done", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        bus_read(32'h4, rd);
        check("post_drain_status", rd, 32'h0000_001A);

        // RX path and underflow
        rx_offer(32'hA5A5_0001);
        rx_offer(32'hA5A5_0002);
        bus_read(32'h0, rd);
        check("rx_read0", rd, 32'hA5A5_0001);
        bus_read(32'h0, rd);
        check("rx_read1", rd, 32'hA5A5_0002);
        bus_read(32'h0, rd);
        check("rx_read_empty", rd, 32'h0);
        bus_read(32'h4, rd);
        check("unf_status", rd, 32'h0000_003A);
        bus_write(32'h8, 32'h1);
        bus_read(32'h4, rd);
        check("clear_status", rd, 32'h0000_000A);
        bus_read(32'h8, rd);
        check("control_reads_zero", rd, 32'h0);

        // Simultaneous push/pop with 3 entries
        for (int i = 0; i < 3; i++) bus_write(32'h0, 32'h21 + i);
        out_ready = 1'b1;
        bus_write(32'h0, 32'h24);
        out_ready = 1'b0;
        bus_read(32'h4, rd);
        check("pp_status", rd, 32'h0000_0308);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("pp_order", out_data, 32'h22 + i);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;

        // Simultaneous push/pop while full: push dropped
        for (int i = 0; i < 8; i++) bus_write(32'h0, 32'h31 + i);
        out_ready = 1'b1;
        bus_write(32'h0, 32'h3F);
        out_ready = 1'b0;
        bus_read(32'h4, rd);
        check("full_pp_status", rd, 32'h0000_0718);
        check("full_pp_head", out_data, 32'h32);
        bus_write(32'h8, 32'h3);
        bus_read(32'h4, rd);
        check("flush_clear_status", rd, 32'h0000_000A);

        // Timer load and wrap
        bus_write(32'hFFFF_FF0C, 32'hFFFF_FFFE);
        bus_read(32'hC, rd);
        check("timer0", rd, 32'hFFFF_FFFE);
        bus_read(32'hC, rd);
        check("timer1", rd, 32'hFFFF_FFFF);
        bus_read(32'hC, rd);
        check("timer2", rd, 32'h0000_0000);

        // Flush keeps sticky flags
        bus_read(32'h0, rd);
        check("unf_read", rd, 32'h0);
        for (int i = 0; i < 5; i++) bus_write(32'h0, 32'h41 + i);
        for (int i = 0; i < 4; i++) rx_offer(32'hB0 + i);
        bus_read(32'h4, rd);
        check("pre_flush_status", rd, 32'h0004_0520);
        bus_write(32'h8, 32'h2);
        bus_read(32'h4, rd);
        check("post_flush_status", rd, 32'h0000_002A);

        // Refill, then asynchronous reset between edges
        bus_write(32'h0, 32'h51);
        bus_write(32'h0, 32'h52);
        rx_offer(32'hC0);
        rx_offer(32'hC1);
        bus_read(32'h4, rd);
        check("refill_status", rd, 32'h0002_0220);
        check("refill_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        cs = 1'b1; wr_rd = 1'b0; addr = 32'h4;
        #1;
        check("arst_status", data_bus_read, 32'h0000_000A);
        rst = 1'b0;
        @(posedge clk); #1;
        cs = 1'b0;
        bus_read(32'h4, rd);
        check("post_rst_status", rd, 32'h0000_000A);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
